// File: rtl/acq_sequencer.sv
// Acquisition sequencer for the event tagger: clear -> arm -> capture window -> flush -> done,
// plus saturating counters for accepted and lost tagger records.
module acq_sequencer #(
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic [31:0] acq_length,
    input  logic [15:0] arm_delay,
    input  logic        record_rdy,
    input  logic        fifo_full,
    output logic        reset_counter,
    output logic        counter_operate,
    output logic        capture_operate,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [2:0]  state,
    output logic [31:0] record_count,
    output logic [15:0] lost_count
);

    localparam int unsigned WIN_W  = 32;
    localparam int unsigned TMR_W  = 16;
    localparam int unsigned REC_W  = 32;
    localparam int unsigned LOST_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ARM   = 3'd2,
        S_RUN   = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic rst;
        logic cnt;
        logic cap;
        logic busy;
        logic done;
    } ctl_t;

    // Tagger controls are loaded together with the state they belong to.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_CLEAR: begin c.rst = 1'b1; c.busy = 1'b1; end
            S_ARM:   begin c.cnt = 1'b1; c.busy = 1'b1; end
            S_RUN:   begin c.cnt = 1'b1; c.cap = 1'b1; c.busy = 1'b1; end
            S_FLUSH: begin c.cnt = 1'b1; c.busy = 1'b1; end
            S_DONE:  begin c.done = 1'b1; c.busy = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t              state_q;
    ctl_t                ctl_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [WIN_W-1:0]    win_q;
    logic [WIN_W-1:0]    len_q;
    logic [TMR_W-1:0]    arm_q;
    logic [REC_W-1:0]    rec_q;
    logic [LOST_W-1:0]   lost_q;
    logic                ovf_q;
    logic                count_en_c;

    assign count_en_c = (state_q == S_RUN) || (state_q == S_FLUSH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            tmr_q   <= '0;
            win_q   <= '0;
            len_q   <= '0;
            arm_q   <= '0;
            rec_q   <= '0;
            lost_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_start && !cmd_stop) begin
                        state_q <= S_CLEAR;
                        ctl_q   <= decode(S_CLEAR);
                        tmr_q   <= '0;
                        len_q   <= acq_length;
                        arm_q   <= arm_delay;
                        rec_q   <= '0;
                        lost_q  <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (cmd_stop) begin
                        state_q <= S_IDLE;
                        ctl_q   <= decode(S_IDLE);
                    end else if (tmr_q == TMR_W'(CLEAR_CYCLES - 1)) begin
                        state_q <= S_ARM;
                        ctl_q   <= decode(S_ARM);
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_ARM: begin
                    // A zero arm delay still spends one cycle in ARM.
                    if (cmd_stop) begin
                        state_q <= S_IDLE;
                        ctl_q   <= decode(S_IDLE);
                    end else if ((arm_q == '0) || (tmr_q == arm_q - TMR_W'(1))) begin
                        state_q <= S_RUN;
                        ctl_q   <= decode(S_RUN);
                        win_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_RUN: begin
                    if (cmd_stop || ((len_q != '0) && (win_q == len_q - WIN_W'(1)))) begin
                        state_q <= S_FLUSH;
                        ctl_q   <= decode(S_FLUSH);
                        tmr_q   <= '0;
                    end else begin
                        win_q <= win_q + WIN_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (tmr_q == TMR_W'(FLUSH_CYCLES - 1)) begin
                        state_q <= S_DONE;
                        ctl_q   <= decode(S_DONE);
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ctl_q   <= decode(S_IDLE);
                end
                default: begin
                    state_q <= S_IDLE;
                    ctl_q   <= '0;
                end
            endcase

            // Record accounting only while the tagger counter is live.
            if (count_en_c && record_rdy) begin
                if (!fifo_full) begin
                    if (rec_q != '1) rec_q <= rec_q + REC_W'(1);
                end else begin
                    if (lost_q != '1) lost_q <= lost_q + LOST_W'(1);
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign state           = state_q;
    assign reset_counter   = ctl_q.rst;
    assign counter_operate = ctl_q.cnt;
    assign capture_operate = ctl_q.cap;
    assign busy            = ctl_q.busy;
    assign done            = ctl_q.done;
    assign overflow        = ovf_q;
    assign record_count    = rec_q;
    assign lost_count      = lost_q;

endmodule
